// File: rtl/arbitro_rr_4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
interface arbitro_rr_4_if;
  logic R0, R1, R2, R3;
  logic G0, G1, G2, G3;
  logic idx1, idx0;
  logic busy;

  modport master (
    output R0, R1, R2, R3,
    input  G0, G1, G2, G3, idx1, idx0, busy
  );

  modport slave (
    input  R0, R1, R2, R3,
    output G0, G1, G2, G3, idx1, idx0, busy
  );
endinterface

// File: rtl/arbitro_rr_4.sv
// Four-way round-robin arbiter with a hold limit; one-hot grant decoded from a registered owner index.
// state | meaning
// IDLE  | no owner, all grants low, idx keeps the previous owner
// GRANT | owner idx holds the resource, hold counts its extra cycles
module arbitro_rr_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  arbitro_rr_4_if.slave  bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_n;
  logic [1:0] idx, idx_n;
  logic [1:0] last, last_n;
  logic [7:0] hold, hold_n;

  logic [3:0] req;
  logic [1:0] win;
  logic [1:0] cand;
  logic       found;
  logic       own;
  logic       others;

  assign req    = {bus.R3, bus.R2, bus.R1, bus.R0};
  assign own    = req[idx];
  assign others = |(req & ~(4'b0001 << idx));

  // The owner sits at offset 4 from itself, so it is always examined last.
  always_comb begin
    win   = last;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    last_n  = last;
    hold_n  = hold;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n = GRANT;
          idx_n   = win;
          last_n  = win;
          hold_n  = '0;
        end
      end
      GRANT: begin
        if (!own) begin
          if (others) begin
            idx_n  = win;
            last_n = win;
            hold_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else if (others && hold == HOLD_LAST) begin
          idx_n  = win;
          last_n = win;
          hold_n = '0;
        end else if (!others) begin
          // Parked at the limit so a late contender preempts on the very next edge.
          hold_n = (hold >= HOLD_LAST) ? HOLD_LAST : hold + 8'd1;
        end else begin
          hold_n = (hold == 8'hFF) ? hold : hold + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 2'd0;
      last  <= 2'd3;
      hold  <= 8'd0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      last  <= last_n;
      hold  <= hold_n;
    end
  end

  assign bus.G0   = (state == GRANT) && (idx == 2'd0);
  assign bus.G1   = (state == GRANT) && (idx == 2'd1);
  assign bus.G2   = (state == GRANT) && (idx == 2'd2);
  assign bus.G3   = (state == GRANT) && (idx == 2'd3);
  assign bus.idx1 = idx[1];
  assign bus.idx0 = idx[0];
  assign bus.busy = (state == GRANT);
endmodule

// File: tb/tb_arbitro_rr_4.sv
// Directed bench for arbitro_rr_4: three instances with MAX_HOLD = 8, 1 and 4.
module tb_arbitro_rr_4;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  arbitro_rr_4_if ifa ();
  arbitro_rr_4_if ifb ();
  arbitro_rr_4_if ifc ();

  arbitro_rr_4 #(.MAX_HOLD(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  arbitro_rr_4 #(.MAX_HOLD(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  arbitro_rr_4 #(.MAX_HOLD(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Snapshot layout: {busy, idx1, idx0, G3, G2, G1, G0}
  function automatic logic [6:0] snap_a();
    return {ifa.busy, ifa.idx1, ifa.idx0, ifa.G3, ifa.G2, ifa.G1, ifa.G0};
  endfunction
  function automatic logic [6:0] snap_b();
    return {ifb.busy, ifb.idx1, ifb.idx0, ifb.G3, ifb.G2, ifb.G1, ifb.G0};
  endfunction
  function automatic logic [6:0] snap_c();
    return {ifc.busy, ifc.idx1, ifc.idx0, ifc.G3, ifc.G2, ifc.G1, ifc.G0};
  endfunction

  function automatic logic [6:0] ex(bit b, int k);
    logic [1:0] i2;
    i2 = 2'(k);
    return {b, i2, b ? (4'b0001 << i2) : 4'b0000};
  endfunction

  task automatic chk(string tag, logic [6:0] obs, logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_a(logic [3:0] r);
    ifa.R0 = r[0]; ifa.R1 = r[1]; ifa.R2 = r[2]; ifa.R3 = r[3];
  endtask
  task automatic set_b(logic [3:0] r);
    ifb.R0 = r[0]; ifb.R1 = r[1]; ifb.R2 = r[2]; ifb.R3 = r[3];
  endtask
  task automatic set_c(logic [3:0] r);
    ifc.R0 = r[0]; ifc.R1 = r[1]; ifc.R2 = r[2]; ifc.R3 = r[3];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    set_a(4'b1111);
    set_b(4'b0000);
    set_c(4'b0000);
    #3;
    chk("reset_a", snap_a(), ex(0, 0));
    step();
    chk("reset_held_a", snap_a(), ex(0, 0));
    chk("reset_held_b", snap_b(), ex(0, 0));
    rst_n = 1'b1;

    // First search starts at R0; all four contend so G0 holds 8 cycles.
    step();
    chk("first_grant_g0", snap_a(), ex(1, 0));
    for (int i = 0; i < 7; i++) begin
      step();
      chk("hold8_g0", snap_a(), ex(1, 0));
    end
    step();
    chk("hold8_next_g1", snap_a(), ex(1, 1));
    set_a(4'b0000);
    step();
    chk("idle_keeps_idx1", snap_a(), ex(0, 1));

    // Lone requester is never preempted.
    set_a(4'b0100);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("single_g2", snap_a(), ex(1, 2));
    end
    set_a(4'b0000);
    step();
    chk("single_drop", snap_a(), ex(0, 2));

    // Release handover G0 -> G2, then hold restarts at zero.
    set_a(4'b0001);
    step();
    chk("handover_g0", snap_a(), ex(1, 0));
    set_a(4'b0101);
    step();
    chk("handover_g0_wait", snap_a(), ex(1, 0));
    set_a(4'b0100);
    step();
    chk("handover_g2", snap_a(), ex(1, 2));
    set_a(4'b0101);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("handover_g2_hold", snap_a(), ex(1, 2));
    end
    step();
    chk("handover_back_g0", snap_a(), ex(1, 0));
    set_a(4'b0000);
    step();
    chk("handover_idle", snap_a(), ex(0, 0));

    // MAX_HOLD=1 rotation: one grant per cycle, no gaps.
    set_b(4'b1111);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("rotate", snap_b(), ex(1, i % 4));
    end
    set_b(4'b0000);
    step();
    chk("rotate_idle", snap_b(), ex(0, 0));

    // MAX_HOLD=4: contender raised one cycle after G1.
    set_c(4'b0010);
    step();
    chk("limit_g1_first", snap_c(), ex(1, 1));
    set_c(4'b1010);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("limit_g1", snap_c(), ex(1, 1));
    end
    step();
    chk("limit_g3_first", snap_c(), ex(1, 3));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("limit_g3", snap_c(), ex(1, 3));
    end
    step();
    chk("limit_back_g1", snap_c(), ex(1, 1));
    set_c(4'b0000);
    step();
    chk("limit_idle", snap_c(), ex(0, 1));

    // Mid-grant asynchronous reset, then R0 wins over R3.
    set_a(4'b1000);
    step();
    chk("midrst_g3", snap_a(), ex(1, 3));
    step();
    chk("midrst_g3_keep", snap_a(), ex(1, 3));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_async_clear", snap_a(), ex(0, 0));
    set_a(4'b1001);
    #1;
    rst_n = 1'b1;
    step();
    chk("midrst_after_g0", snap_a(), ex(1, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
